// File: rtl/keccak_squeeze_ctrl_if.sv
// Handshake and configuration bundle between the squeeze controller and its
// surroundings (job control, permutation core, lane mux and output consumer).
//   master : the squeeze controller (drives sel/out_valid/out_last/perm_start/busy/done)
//   slave  : the environment (drives start/num_lanes/num_blocks/abort/out_ready/perm_done)
interface keccak_squeeze_ctrl_if #(
  parameter int BLK_W = 8
);
  logic             start;
  logic [3:0]       num_lanes;
  logic [BLK_W-1:0] num_blocks;
  logic             abort;
  logic             out_ready;
  logic             perm_done;
  logic [3:0]       sel;
  logic             out_valid;
  logic             out_last;
  logic             perm_start;
  logic             busy;
  logic             done;

  modport master (
    input  start, num_lanes, num_blocks, abort, out_ready, perm_done,
    output sel, out_valid, out_last, perm_start, busy, done
  );

  modport slave (
    output start, num_lanes, num_blocks, abort, out_ready, perm_done,
    input  sel, out_valid, out_last, perm_start, busy, done
  );
endinterface

// File: rtl/keccak_squeeze_ctrl.sv
// Keccak squeeze sequencer: walks the rate lanes through the 12-way lane mux,
// streaming one lane per out_valid/out_ready handshake, and requests a
// permutation from the round core between output blocks.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - keccak_squeeze_ctrl_if.master:
//          start/num_lanes/num_blocks  job launch and configuration (IDLE only)
//          abort                       synchronous cancel of the running job
//          out_ready                   consumer accepts the current lane
//          perm_done                   permutation finished pulse
//          sel                         lane select to the mux
//          out_valid/out_last          lane valid / final lane of final block
//          perm_start                  one-cycle permutation request
//          busy/done                   job in progress / completion pulse
module keccak_squeeze_ctrl #(
  parameter int MAX_LANES = 12,
  parameter int BLK_W     = 8
) (
  input logic                   clk,
  input logic                   rst,
  keccak_squeeze_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STREAM  = 2'd1,
    PERMUTE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [3:0]       NL_MAX   = 4'(MAX_LANES);
  localparam logic [3:0]       LANE_ONE = 4'd1;
  localparam logic [BLK_W-1:0] BLK_ONE  = BLK_W'(1);

  state_t           state, state_n;
  logic [3:0]       lane, lane_n;
  logic [BLK_W-1:0] blk, blk_n;
  logic [3:0]       nl, nl_n;
  logic [BLK_W-1:0] nb, nb_n;
  logic             perm_start_n;

  logic xfer;
  logic lane_end;
  logic blk_end;

  assign xfer     = bus.out_valid && bus.out_ready;
  assign lane_end = (lane == nl - LANE_ONE);
  assign blk_end  = (blk == nb - BLK_ONE);

  always_comb begin
    state_n      = state;
    lane_n       = lane;
    blk_n        = blk;
    nl_n         = nl;
    nb_n         = nb;
    perm_start_n = 1'b0;

    if (state != IDLE && bus.abort) begin
      state_n = IDLE;
      lane_n  = '0;
      blk_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            // Out-of-range lane counts and an empty block count are clamped
            // so the job always emits at least one full lane sequence.
            nl_n    = (bus.num_lanes == '0 || bus.num_lanes > NL_MAX) ? NL_MAX : bus.num_lanes;
            nb_n    = (bus.num_blocks == '0) ? BLK_ONE : bus.num_blocks;
            lane_n  = '0;
            blk_n   = '0;
            state_n = STREAM;
          end
        end
        STREAM: begin
          if (xfer) begin
            if (!lane_end) begin
              lane_n = lane + LANE_ONE;
            end else if (!blk_end) begin
              lane_n       = '0;
              blk_n        = blk + BLK_ONE;
              state_n      = PERMUTE;
              perm_start_n = 1'b1;
            end else begin
              state_n = DONE;
            end
          end
        end
        PERMUTE: begin
          if (bus.perm_done) begin
            state_n = STREAM;
          end
        end
        DONE: begin
          state_n = IDLE;
          lane_n  = '0;
          blk_n   = '0;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // All outputs are registered from the next-state values so they line up
  // with the state they describe on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      lane           <= '0;
      blk            <= '0;
      nl             <= '0;
      nb             <= '0;
      bus.sel        <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_last   <= 1'b0;
      bus.perm_start <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
    end else begin
      state          <= state_n;
      lane           <= lane_n;
      blk            <= blk_n;
      nl             <= nl_n;
      nb             <= nb_n;
      bus.sel        <= (state_n == STREAM) ? lane_n : '0;
      bus.out_valid  <= (state_n == STREAM);
      bus.out_last   <= (state_n == STREAM) &&
                        (lane_n == nl_n - LANE_ONE) &&
                        (blk_n == nb_n - BLK_ONE);
      bus.perm_start <= perm_start_n;
      bus.busy       <= (state_n != IDLE);
      bus.done       <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_keccak_squeeze_ctrl.sv
module tb_keccak_squeeze_ctrl;

  localparam int BLK_W     = 8;
  localparam int MAX_LANES = 12;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  keccak_squeeze_ctrl_if #(.BLK_W(BLK_W)) bus ();

  keccak_squeeze_ctrl #(.MAX_LANES(MAX_LANES), .BLK_W(BLK_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard of expected {sel, out_last} per accepted lane.
  logic [4:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.out_ready  = 1'b0;
    bus.perm_done  = 1'b0;
    bus.num_lanes  = '0;
    bus.num_blocks = '0;
  endtask

  task automatic run_job(input logic [3:0] lanes_in, input logic [BLK_W-1:0] blocks_in,
                         input int perm_lat, input int stall_cycles, input string tag);
    int         enl, enb, n, pcount, stall_left, nperm, ndone, done_at;
    logic [4:0] e;
    logic [3:0] hold_sel;
    logic       hold_last;
    logic       pd_prev;
    bit         finished;

    enl = (lanes_in == 4'd0 || int'(lanes_in) > MAX_LANES) ? MAX_LANES : int'(lanes_in);
    enb = (blocks_in == '0) ? 1 : int'(blocks_in);
    for (int b = 0; b < enb; b++)
      for (int l = 0; l < enl; l++)
        exp_q.push_back({4'(l), (l == enl - 1) && (b == enb - 1)});
    done_at = enl * enb + (enb - 1) * perm_lat + stall_cycles + 1;

    pcount = 0; stall_left = stall_cycles; nperm = 0; ndone = 0;
    pd_prev = 1'b0; finished = 1'b0; hold_sel = '0; hold_last = 1'b0;

    @(negedge clk);
    bus.start = 1'b1; bus.num_lanes = lanes_in; bus.num_blocks = blocks_in; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, ":first_valid"}, 32'(bus.out_valid), 32'd1);

    n = 1;
    while (!finished && n < 2000) begin
      if (pd_prev) check({tag, ":pd_to_valid"}, 32'(bus.out_valid), 32'd1);
      pd_prev = 1'b0;
      if (bus.perm_start) begin
        nperm++;
        check({tag, ":perm_sel"}, 32'(bus.sel), 32'd0);
        check({tag, ":perm_valid"}, 32'(bus.out_valid), 32'd0);
        pcount = perm_lat;
      end
      bus.perm_done = 1'b0;
      if (pcount > 0) begin
        pcount--;
        if (pcount == 0) begin
          bus.perm_done = 1'b1;
          pd_prev = 1'b1;
        end
      end
      if (bus.done) begin
        ndone++;
        check({tag, ":done_cycle"}, 32'(n), 32'(done_at));
        check({tag, ":done_valid"}, 32'(bus.out_valid), 32'd0);
        finished = 1'b1;
      end else begin
        check({tag, ":busy"}, 32'(bus.busy), 32'd1);
      end
      if (bus.out_valid && bus.sel == 4'd1 && stall_left > 0) begin
        if (stall_left == stall_cycles) begin
          hold_sel  = bus.sel;
          hold_last = bus.out_last;
        end else begin
          check({tag, ":hold_sel"}, 32'(bus.sel), 32'(hold_sel));
          check({tag, ":hold_valid"}, 32'(bus.out_valid), 32'd1);
          check({tag, ":hold_last"}, 32'(bus.out_last), 32'(hold_last));
        end
        bus.out_ready = 1'b0;
        stall_left--;
      end else begin
        bus.out_ready = 1'b1;
      end
      if (bus.out_valid && bus.out_ready) begin
        n_cmp++;
        assert (exp_q.size() > 0) else begin
          n_err++;
          $error("FAIL %s:extra_lane: observed sel %0d expected no transfer", tag, bus.sel);
        end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check({tag, ":sel"}, 32'(bus.sel), 32'(e[4:1]));
          check({tag, ":last"}, 32'(bus.out_last), 32'(e[0]));
        end
      end
      if (!finished) begin
        @(negedge clk);
        n++;
      end
    end

    n_cmp++;
    assert (finished) else begin
      n_err++;
      $error("FAIL %s:timeout: observed no done after %0d cycles expected done", tag, n);
    end
    check({tag, ":lanes_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, ":perm_count"}, 32'(nperm), 32'(enb - 1));
    exp_q.delete();
    bus.out_ready = 1'b0;
    bus.perm_done = 1'b0;
    @(negedge clk);
    check({tag, ":done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, ":busy_after"}, 32'(bus.busy), 32'd0);
    check({tag, ":valid_after"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    idle_inputs();
    #1;
    check("rst_sel", 32'(bus.sel), 32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_last", 32'(bus.out_last), 32'd0);
    check("rst_perm_start", 32'(bus.perm_start), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_job(4'd12, 8'd1, 1, 0, "nl12");
    run_job(4'd3,  8'd2, 5, 0, "nl3nb2");
    run_job(4'd3,  8'd3, 1, 0, "pd_same_cycle");
    run_job(4'd4,  8'd1, 1, 4, "stall");
    run_job(4'd0,  8'd1, 1, 0, "nl0");
    run_job(4'd15, 8'd1, 1, 0, "nl15");
    run_job(4'd2,  8'd0, 1, 0, "nb0");

    // abort coinciding with a transfer at sel=5
    @(negedge clk);
    bus.start = 1'b1; bus.num_lanes = 4'd12; bus.num_blocks = 8'd2; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (bus.sel != 4'd5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("abort_xfer:reach_sel5", 32'(bus.sel), 32'd5);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0; bus.out_ready = 1'b0;
    check("abort_xfer:valid", 32'(bus.out_valid), 32'd0);
    check("abort_xfer:busy", 32'(bus.busy), 32'd0);
    check("abort_xfer:sel", 32'(bus.sel), 32'd0);
    check("abort_xfer:done", 32'(bus.done), 32'd0);
    @(negedge clk);
    check("abort_xfer:done_later", 32'(bus.done), 32'd0);
    run_job(4'd5, 8'd1, 1, 0, "after_abort_xfer");

    // abort coinciding with perm_done in the perm_start cycle
    @(negedge clk);
    bus.start = 1'b1; bus.num_lanes = 4'd3; bus.num_blocks = 8'd2; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (!bus.perm_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("abort_pd:reach_perm", 32'(bus.perm_start), 32'd1);
    bus.abort = 1'b1; bus.perm_done = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0; bus.perm_done = 1'b0; bus.out_ready = 1'b0;
    check("abort_pd:valid", 32'(bus.out_valid), 32'd0);
    check("abort_pd:busy", 32'(bus.busy), 32'd0);
    check("abort_pd:perm_start", 32'(bus.perm_start), 32'd0);
    check("abort_pd:sel", 32'(bus.sel), 32'd0);
    @(negedge clk);
    check("abort_pd:done_later", 32'(bus.done), 32'd0);
    check("abort_pd:valid_later", 32'(bus.out_valid), 32'd0);
    run_job(4'd3, 8'd1, 1, 0, "after_abort_pd");

    // start and abort together in IDLE: start wins
    @(negedge clk);
    bus.start = 1'b1; bus.abort = 1'b1; bus.num_lanes = 4'd2; bus.num_blocks = 8'd1;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    check("start_abort:busy", 32'(bus.busy), 32'd1);
    check("start_abort:valid", 32'(bus.out_valid), 32'd1);
    check("start_abort:sel", 32'(bus.sel), 32'd0);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("start_abort:cancel", 32'(bus.busy), 32'd0);

    // asynchronous reset mid-stream, then a stray perm_done
    @(negedge clk);
    bus.start = 1'b1; bus.num_lanes = 4'd12; bus.num_blocks = 8'd2; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (bus.sel != 4'd3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid:reach_sel3", 32'(bus.sel), 32'd3);
    #2 rst = 1'b1;
    #1;
    check("rst_mid:sel", 32'(bus.sel), 32'd0);
    check("rst_mid:valid", 32'(bus.out_valid), 32'd0);
    check("rst_mid:busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst = 1'b0; bus.out_ready = 1'b0; bus.perm_done = 1'b1;
    @(negedge clk);
    bus.perm_done = 1'b0;
    check("rst_mid:pd_busy", 32'(bus.busy), 32'd0);
    check("rst_mid:pd_valid", 32'(bus.out_valid), 32'd0);
    check("rst_mid:pd_perm_start", 32'(bus.perm_start), 32'd0);
    check("rst_mid:pd_sel", 32'(bus.sel), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
